// File: rtl/vsdserializer_pkg.sv
// Shared constants and helpers for the vsdserializer parallel-to-serial block.
package vsdserializer_pkg;

    localparam int DEFAULT_WIDTH = 10;

    // The counter must hold every value from 0 up to the full word length.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/vsdserializer_bitcnt.sv
// Loadable down-counter that tracks the unsent bits of the current word.
// It also decodes busy and last from the count.
module vsdserializer_bitcnt
    import vsdserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // The count saturates at zero, so an idle serializer stays idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= FULL;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign busy = (cnt != '0);
    assign last = (cnt == ONE);

endmodule

// File: rtl/vsdserializer_v1.sv
// Parallel-to-serial converter. OUTPUT is taken straight from the end of the
// shift register, so the first bit appears in the cycle right after the load.
module vsdserializer_v1
    import vsdserializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] INPUT,
    output logic             OUTPUT,
    input  logic             rst_n,
    output logic             busy,
    output logic             last
);

    logic [WIDTH-1:0] sreg;

    // A load always wins over shifting, which makes a reload abort the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= INPUT;
        end else if (MSB_FIRST) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
    end

    assign OUTPUT = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    vsdserializer_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .busy (busy),
        .last (last)
    );

endmodule

// File: tb/tb_vsdserializer_v1.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus and a
// per-cycle scoreboard of expected bits.
module tb_vsdserializer_v1;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         rst_n = 1'b0;
    logic         out_m, busy_m, last_m;
    logic         out_l, busy_l, last_l;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic om;
        logic ol;
        logic lst;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    vsdserializer_v1 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .load(load), .INPUT(data_in), .OUTPUT(out_m),
        .rst_n(rst_n), .busy(busy_m), .last(last_m)
    );

    vsdserializer_v1 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .load(load), .INPUT(data_in), .OUTPUT(out_l),
        .rst_n(rst_n), .busy(busy_l), .last(last_l)
    );

    // Observed outputs of both instances packed as {out_m,out_l,busy_m,last_m,busy_l,last_l}.
    function automatic logic [5:0] observed();
        return {out_m, out_l, busy_m, last_m, busy_l, last_l};
    endfunction

    function automatic logic [5:0] expected();
        exp_t f;
        if (sb.size() == 0) return 6'b0;
        f = sb[0];
        return {f.om, f.ol, 1'b1, f.lst, 1'b1, f.lst};
    endfunction

    // Drives one edge's worth of inputs, updates the scoreboard, then samples 1ns later.
    task automatic applyStimulus(input logic ld, input logic [W-1:0] d, input logic rn);
        @(negedge clk);
        load    = ld;
        data_in = d;
        rst_n   = rn;
        @(posedge clk);
        if (!rn) begin
            sb.delete();
        end else if (ld) begin
            sb.delete();
            for (int k = 0; k < W; k++) begin
                sb.push_back('{om: d[W-1-k], ol: d[k], lst: (k == W-1)});
            end
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs, exv;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        obs = observed(); exv = expected();
        checks++;
        if (obs !== exv || obs !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_state got=%b want=%b", obs, 6'b0);
        end
        applyStimulus(1'b1, 10'h3FF, 1'b0);
        obs = observed(); exv = expected();
        checks++;
        if (obs !== exv) begin
            errors++; $display("[TB] FAIL reset_over_load got=%b want=%b", obs, exv);
        end
        applyStimulus(1'b0, 10'h3FF, 1'b1);
        obs = observed(); exv = expected();
        checks++;
        if (obs !== exv) begin
            errors++; $display("[TB] FAIL idle_after_reset got=%b want=%b", obs, exv);
        end
    endtask

    task automatic test_pattern();
        logic [5:0] obs, exv;
        logic [W-1:0] seq_m, seq_l, lastseq;
        applyStimulus(1'b1, 10'b1011001110, 1'b1);
        for (int i = 0; i < W + 2; i++) begin
            obs = observed(); exv = expected();
            if (i < W) begin
                seq_m[W-1-i]   = out_m;
                seq_l[W-1-i]   = out_l;
                lastseq[W-1-i] = last_m;
            end
            checks++;
            if (obs !== exv) begin
                errors++; $display("[TB] FAIL pattern cyc=%0d got=%b want=%b", i, obs, exv);
            end
            applyStimulus(1'b0, W'($urandom), 1'b1);
        end
        checks++;
        if (seq_m !== 10'b1011001110) begin
            errors++; $display("[TB] FAIL msb_stream got=%b want=%b", seq_m, 10'b1011001110);
        end
        checks++;
        if (seq_l !== 10'b0111001101) begin
            errors++; $display("[TB] FAIL lsb_stream got=%b want=%b", seq_l, 10'b0111001101);
        end
        checks++;
        if (lastseq !== 10'b0000000001) begin
            errors++; $display("[TB] FAIL last_timing got=%b want=%b", lastseq, 10'b0000000001);
        end
    endtask

    task automatic test_abort();
        logic [5:0] obs, exv;
        applyStimulus(1'b1, 10'h3FF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            obs = observed(); exv = expected();
            checks++;
            if (obs !== exv) begin
                errors++; $display("[TB] FAIL abort_first cyc=%0d got=%b want=%b", i, obs, exv);
            end
            if (i < 3) applyStimulus(1'b0, 10'h3FF, 1'b1);
        end
        applyStimulus(1'b1, 10'h000, 1'b1);
        for (int i = 0; i < W + 2; i++) begin
            obs = observed(); exv = expected();
            checks++;
            if (obs !== exv) begin
                errors++; $display("[TB] FAIL abort_second cyc=%0d got=%b want=%b", i, obs, exv);
            end
            applyStimulus(1'b0, 10'h3FF, 1'b1);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [5:0] obs, exv;
        applyStimulus(1'b1, 10'h2AA, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        obs = observed(); exv = expected();
        checks++;
        if (obs !== exv) begin
            errors++; $display("[TB] FAIL pre_reset got=%b want=%b", obs, exv);
        end
        applyStimulus(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            obs = observed(); exv = expected();
            checks++;
            if (obs !== exv || obs !== 6'b0) begin
                errors++; $display("[TB] FAIL post_reset cyc=%0d got=%b want=%b", i, obs, 6'b0);
            end
            applyStimulus(1'b0, 10'h3FF, 1'b1);
        end
    endtask

    task automatic test_hold_load();
        logic [5:0] obs, exv;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 10'h200 : 10'h000, 1'b1);
            obs = observed(); exv = expected();
            checks++;
            if (obs !== exv) begin
                errors++; $display("[TB] FAIL hold_load cyc=%0d got=%b want=%b", i, obs, exv);
            end
        end
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] obs, exv;
        logic [19:0] stream;
        logic saw_last;
        applyStimulus(1'b1, 10'h155, 1'b1);
        for (int i = 0; i < 2 * W; i++) begin
            obs = observed(); exv = expected();
            stream[19-i] = out_m;
            checks++;
            if (obs !== exv) begin
                errors++; $display("[TB] FAIL b2b cyc=%0d got=%b want=%b", i, obs, exv);
            end
            if (i == W - 1) begin
                saw_last = last_m;
                applyStimulus(1'b1, 10'h3FF, 1'b1);
            end else begin
                applyStimulus(1'b0, W'($urandom), 1'b1);
            end
        end
        checks++;
        if (saw_last !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_last got=%b want=1", saw_last);
        end
        checks++;
        if (stream !== 20'b01010101011111111111) begin
            errors++; $display("[TB] FAIL b2b_stream got=%b want=%b", stream, 20'b01010101011111111111);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_abort();
        test_reset_mid_word();
        test_hold_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vsdserializer_v1.md
VSDSERIALIZER_V1 -- requirements
Module: vsdserializer_v1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port order SHALL be clk, load, INPUT, OUTPUT, rst_n, busy, last, so a positional four-port instantiation (clk, load, INPUT, OUTPUT) stays legal.
REQ-003 Parameter WIDTH SHALL default to 10: number of parallel bits per word (minimum 2).
REQ-004 Parameter MSB_FIRST SHALL default to 1: 1 = shift INPUT[WIDTH-1] first, 0 = shift INPUT[0] first.
REQ-005 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset; sampled on the rising clk edge.
REQ-007 load  input  1  parallel-load strobe; sampled on the rising clk edge.
REQ-008 INPUT  input  WIDTH  parallel word; captured on an edge where load=1.
REQ-009 OUTPUT  output  1  serial data bit; driven directly from the shift-register end bit, with no extra register stage.
REQ-010 busy  output  1  high while unsent bits of the current word remain on or behind OUTPUT.
REQ-011 last  output  1  high during the cycle in which OUTPUT carries the final bit of the word.

Function
REQ-012 State SHALL be a WIDTH-bit shift register sreg and a bit counter cnt of width clog2(WIDTH+1).
REQ-013 On an edge with rst_n=1 and load=1: sreg <= INPUT and cnt <= WIDTH.
REQ-014 On an edge with rst_n=1 and load=0, sreg SHALL shift one position toward the output end with zero fill; with MSB_FIRST=1 this is {sreg[WIDTH-2:0],0}, otherwise {0,sreg[WIDTH-1:1]}.
REQ-015 On the same edge (rst_n=1, load=0), cnt SHALL decrement if it is nonzero and hold at 0 otherwise.
REQ-016 OUTPUT SHALL equal sreg[WIDTH-1] when MSB_FIRST=1 and sreg[0] when MSB_FIRST=0.
REQ-017 Latency: the first bit SHALL appear on OUTPUT immediately after the load edge (cycle 0); bit k SHALL appear in cycle k, for k = 0..WIDTH-1.
REQ-018 After WIDTH bits, OUTPUT SHALL be 0 until the next load.
REQ-019 busy SHALL equal (cnt != 0), and last SHALL equal (cnt == 1).
REQ-020 A load during an active word SHALL abort the word, discard the remaining bits and restart with the new INPUT; no bit of the old word may appear after that edge.
REQ-021 If load is held high across consecutive edges, the block SHALL reload every edge, so OUTPUT tracks the end bit of the latest INPUT and cnt stays at WIDTH.
REQ-022 A load on the edge where last=1 SHALL produce back-to-back words with no idle cycle.
REQ-023 INPUT SHALL be ignored on edges where load=0.
REQ-024 There SHALL be no combinational path from INPUT or load to any output.

Reset
REQ-025 An edge with rst_n=0 SHALL set sreg to 0 and cnt to 0, which gives OUTPUT=0, busy=0 and last=0.
REQ-026 Reset SHALL take priority over load.
REQ-027 A reset mid-word SHALL abort the word, with no resumption after rst_n returns high.
REQ-028 Before the first reset or load, state SHALL be treated as unknown; the bench SHALL reset first.

Structure
REQ-029 A shared package vsdserializer_pkg SHALL hold the constant DEFAULT_WIDTH=10 and the counter-width function (clog2(WIDTH+1)).
REQ-030 One sub-module, vsdserializer_bitcnt (a loadable down-counter with busy and last decode), is natural.
REQ-031 The shift register SHALL live in the top module.

Verification
REQ-032 Reset, then load INPUT=10'b1011001110 for one edge -> OUTPUT over cycles 0..9 = 1,0,1,1,0,0,1,1,1,0, then 0; busy high for cycles 0..9; last high only in cycle 9.
REQ-033 Same stimulus with MSB_FIRST=0 -> OUTPUT over cycles 0..9 = 0,1,1,1,0,0,1,1,0,1.
REQ-034 Load 10'h3FF, then load 10'h000 after 4 shifts -> OUTPUT = 1,1,1,1, then 0 for 10 cycles; busy stays high 10 cycles after the second load.
REQ-035 Load 10'h2AA, then assert rst_n=0 for one edge after 3 shifts -> OUTPUT, busy and last = 0 from that edge on; no further bits.
REQ-036 Hold load=1 while INPUT alternates 10'h200 and 10'h000 each cycle -> OUTPUT alternates 1,0; busy stays high; last=0.
REQ-037 Load 10'h155, then load 10'h3FF on the last=1 edge -> contiguous 20-bit stream 0,1,0,1,0,1,0,1,0,1,1,1,1,1,1,1,1,1,1,1.
